// File: rtl/mips_pkg.sv
// Shared opcode constants for the MIPS execute stage and its multiply/divide unit.
package mips_pkg;

  localparam int unsigned MD_CYCLES_DEFAULT = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ZERO  = 2'b11;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // MULT, MULTU, DIV and DIVU occupy 0x18..0x1B.
  function automatic logic is_md_funct(input logic [5:0] f);
    return (f >= FUNCT_MULT) && (f <= FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step
// per advancing cycle, with HI/LO written on the final step.
module md_unit #(
  parameter int unsigned MD_CYCLES = mips_pkg::MD_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,        // {is_div, is_unsigned}
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_last_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  import mips_pkg::*;

  localparam int unsigned      CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_p_q, neg_p_d;   // negate product / quotient
  logic             neg_r_q, neg_r_d;   // negate remainder
  logic [31:0]      opb_q, opb_d;       // multiplicand or divisor magnitude
  logic [63:0]      acc_q, acc_d;       // {partial, multiplier} or {remainder, quotient}
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] step_acc;
  logic [63:0] prod_fix;
  logic [31:0] fix_hi, fix_lo;
  logic        last;

  // Operand magnitudes; unsigned ops never see a sign.
  always_comb begin
    sign_a = ~op_i[0] & a_i[31];
    sign_b = ~op_i[0] & b_i[31];
    mag_a  = sign_a ? (32'd0 - a_i) : a_i;
    mag_b  = sign_b ? (32'd0 - b_i) : b_i;
  end

  // One iteration of the datapath plus the sign fix-up applied on the last one.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ge    = div_shift >= {1'b0, opb_q};
    // The true difference is below the divisor, so 32 bits are enough.
    div_rem   = div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
    div_next  = {div_rem, acc_q[30:0], div_ge};
    step_acc  = is_div_q ? div_next : mul_next;
    prod_fix  = neg_p_q ? (64'd0 - step_acc) : step_acc;
    if (is_div_q) begin
      fix_lo = neg_p_q ? (32'd0 - step_acc[31:0])  : step_acc[31:0];
      fix_hi = neg_r_q ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
    end else begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end
  end

  // Next-state for the IDLE/BUSY FSM, counter, datapath and HI/LO.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    last     = (state_q == MD_BUSY) && (cnt_q == CNT_LAST);
    if (adv_i) begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            is_div_d = op_i[1];
            neg_r_d  = op_i[1] & sign_a;
            if (op_i[1]) begin
              // Divide by zero keeps the raw all-ones quotient.
              neg_p_d = (sign_a ^ sign_b) & (b_i != 32'd0);
              opb_d   = mag_b;
              acc_d   = {32'd0, mag_a};
            end else begin
              neg_p_d = sign_a ^ sign_b;
              opb_d   = mag_a;
              acc_d   = {32'd0, mag_b};
            end
            cnt_d   = '0;
            state_d = MD_BUSY;
          end
        end
        MD_BUSY: begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            cnt_d   = '0;
            state_d = MD_IDLE;
          end
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // State register with synchronous reset; reset abandons any op in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_last_o = last;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage with EX/MEM pipeline register and iterative multiply/divide.
module ex_stage_md
  import mips_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_hit,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic [3:0]  ex_ctl,
  input  logic [29:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [29:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic        stall_req,
  output logic [1:0]  wb_ctlout,
  output logic [2:0]  m_ctlout,
  output logic [29:0] branch_target,
  output logic        zero_out,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  dest_reg
);

  logic        regdst, alusrc;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] op_b;
  logic        md_op;
  logic        busy_last;
  logic [31:0] hi, lo;
  logic [31:0] alu_d;

  logic [1:0]  wb_q, wb_d;
  logic [2:0]  m_q, m_d;
  logic [29:0] bt_q, bt_d;
  logic        zero_q, zero_d;
  logic [31:0] alu_q, alu_q_d;
  logic [31:0] rd2_q, rd2_d;
  logic [4:0]  dest_q, dest_d;

  // Control decode and operand B select.
  always_comb begin
    regdst = ex_ctl[3];
    aluop  = ex_ctl[2:1];
    alusrc = ex_ctl[0];
    funct  = s_extend[5:0];
    op_b   = alusrc ? {{2{s_extend[29]}}, s_extend} : rdata2;
    md_op  = (aluop == ALUOP_RTYPE) && is_md_funct(funct);
  end

  md_unit #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md (
    .clk_i      (clk),
    .rst_i      (rst),
    .adv_i      (data_hit),
    .start_i    (md_op),
    .op_i       (funct[1:0]),
    .a_i        (rdata1),
    .b_i        (op_b),
    .busy_last_o(busy_last),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  // Upstream holds until the multiply/divide reaches its final step.
  always_comb begin
    stall_req = md_op & ~busy_last;
  end

  // ALU result, including HI/LO moves; multiply/divide retires with 0.
  always_comb begin
    alu_d = '0;
    case (aluop)
      ALUOP_ADD: alu_d = rdata1 + op_b;
      ALUOP_SUB: alu_d = rdata1 - op_b;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  alu_d = rdata1 + op_b;
          FUNCT_SUB:  alu_d = rdata1 - op_b;
          FUNCT_AND:  alu_d = rdata1 & op_b;
          FUNCT_OR:   alu_d = rdata1 | op_b;
          FUNCT_SLT:  alu_d = {31'd0, $signed(rdata1) < $signed(op_b)};
          FUNCT_MFHI: alu_d = hi;
          FUNCT_MFLO: alu_d = lo;
          default:    alu_d = '0;
        endcase
      end
      default: alu_d = '0;
    endcase
  end

  // EX/MEM next-state: full load when advancing, bubble while stalled.
  always_comb begin
    wb_d    = wb_q;
    m_d     = m_q;
    bt_d    = bt_q;
    zero_d  = zero_q;
    alu_q_d = alu_q;
    rd2_d   = rd2_q;
    dest_d  = dest_q;
    if (data_hit) begin
      if (!stall_req) begin
        wb_d    = wb_ctl;
        m_d     = m_ctl;
        bt_d    = npc + s_extend;
        zero_d  = (alu_d == 32'd0);
        alu_q_d = alu_d;
        rd2_d   = rdata2;
        dest_d  = regdst ? instr_1511 : instr_2016;
      end else begin
        wb_d = '0;
        m_d  = '0;
      end
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q   <= '0;
      m_q    <= '0;
      bt_q   <= '0;
      zero_q <= 1'b0;
      alu_q  <= '0;
      rd2_q  <= '0;
      dest_q <= '0;
    end else begin
      wb_q   <= wb_d;
      m_q    <= m_d;
      bt_q   <= bt_d;
      zero_q <= zero_d;
      alu_q  <= alu_q_d;
      rd2_q  <= rd2_d;
      dest_q <= dest_d;
    end
  end

  assign wb_ctlout     = wb_q;
  assign m_ctlout      = m_q;
  assign branch_target = bt_q;
  assign zero_out      = zero_q;
  assign alu_result    = alu_q;
  assign rdata2out     = rd2_q;
  assign dest_reg      = dest_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Randomized bench for ex_stage_md against a cycle-level behavioural model.
module tb_ex_stage_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_hit;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic [3:0]  ex_ctl;
  logic [29:0] npc;
  logic [31:0] rdata1, rdata2;
  logic [29:0] s_extend;
  logic [4:0]  instr_2016, instr_1511;
  logic        stall_req;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [29:0] branch_target;
  logic        zero_out;
  logic [31:0] alu_result, rdata2out;
  logic [4:0]  dest_reg;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [1:0]  e_wb;
  logic [2:0]  e_m;
  logic [29:0] e_bt;
  logic        e_zero;
  logic [31:0] e_alu, e_rd2;
  logic [4:0]  e_dest;
  logic [31:0] m_hi, m_lo;
  int          md_adv;      // advancing cycles the current MD op has spent in EX
  bit          md_retired;
  int          stall_seen;

  ex_stage_md #(.MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .data_hit(data_hit),
    .wb_ctl(wb_ctl), .m_ctl(m_ctl), .ex_ctl(ex_ctl), .npc(npc),
    .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
    .instr_2016(instr_2016), .instr_1511(instr_1511),
    .stall_req(stall_req), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
    .branch_target(branch_target), .zero_out(zero_out),
    .alu_result(alu_result), .rdata2out(rdata2out), .dest_reg(dest_reg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opb_now();
    return ex_ctl[0] ? {{2{s_extend[29]}}, s_extend} : rdata2;
  endfunction

  function automatic bit is_md_now();
    return (ex_ctl[2:1] == 2'b10) && (s_extend[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic [31:0] ref_alu();
    logic [31:0] a, b;
    a = rdata1;
    b = opb_now();
    case (ex_ctl[2:1])
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return 32'd0;
      default: begin
        case (s_extend[5:0])
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h10: return m_hi;
          6'h12: return m_lo;
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  // HI/LO from plain arithmetic on the held operands.
  task automatic md_complete();
    logic [31:0] a, b;
    longint sa, sb;
    logic [63:0] p;
    a = rdata1;
    b = opb_now();
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (s_extend[5:0])
      6'h18: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h19: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h1A: begin
        if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
        else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
  endtask

  task automatic model_reset();
    e_wb = '0; e_m = '0; e_bt = '0; e_zero = 1'b0;
    e_alu = '0; e_rd2 = '0; e_dest = '0;
    m_hi = '0; m_lo = '0; md_adv = 0;
  endtask

  task automatic check_outputs();
    check("wb_ctlout", wb_ctlout, e_wb);
    check("m_ctlout", m_ctlout, e_m);
    check("branch_target", branch_target, e_bt);
    check("zero_out", zero_out, e_zero);
    check("alu_result", alu_result, e_alu);
    check("rdata2out", rdata2out, e_rd2);
    check("dest_reg", dest_reg, e_dest);
  endtask

  // One clock: check stall before the edge, update the model at the edge, check after.
  task automatic step(input bit dh);
    bit exp_stall;
    logic [31:0] alu_v;
    data_hit = dh;
    @(negedge clk);
    exp_stall = is_md_now() && (md_adv != 32);
    check("stall_req", stall_req, exp_stall);
    if (stall_req === 1'b1) stall_seen++;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (dh) begin
      if (exp_stall) begin
        md_adv++;
        e_wb = '0;
        e_m  = '0;
      end else begin
        alu_v = is_md_now() ? 32'd0 : ref_alu();
        if (is_md_now()) begin
          md_complete();
          md_adv = 0;
          md_retired = 1;
        end
        e_wb   = wb_ctl;
        e_m    = m_ctl;
        e_bt   = npc + s_extend;
        e_alu  = alu_v;
        e_zero = (alu_v == 32'd0);
        e_rd2  = rdata2;
        e_dest = ex_ctl[3] ? instr_1511 : instr_2016;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic set_instr(input logic [3:0] ctl, input logic [29:0] imm,
                           input logic [31:0] a, input logic [31:0] b);
    wb_ctl     = 2'($urandom);
    m_ctl      = 3'($urandom);
    npc        = 30'($urandom);
    ex_ctl     = ctl;
    s_extend   = imm;
    rdata1     = a;
    rdata2     = b;
    instr_2016 = 5'($urandom);
    instr_1511 = 5'($urandom);
  endtask

  task automatic rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    set_instr(4'b1100, {24'($urandom), f}, a, b);
  endtask

  // Run the held MD op to retirement, optionally freezing data_hit partway.
  task automatic run_md(input int freeze_at, input int freeze_len);
    md_retired = 0;
    for (int i = 0; i < 200 && !md_retired; i++) begin
      if (i == freeze_at) repeat (freeze_len) step(1'b0);
      step(1'b1);
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0: return 32'($signed($urandom_range(0, 16)) - 8);
      1: return 32'd0;
      2: return $urandom;
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'h80000000;
          1: return 32'h7FFFFFFF;
          2: return 32'd1;
          default: return 32'hFFFFFFFF;
        endcase
      end
    endcase
  endfunction

  initial begin
    logic [5:0] fn_list [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12};
    logic [5:0] md_list [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};
    logic [5:0] f;
    logic [3:0] ctl;

    rst = 1'b1; data_hit = 1'b0;
    wb_ctl = '0; m_ctl = '0; ex_ctl = '0; npc = '0; rdata1 = '0; rdata2 = '0;
    s_extend = '0; instr_2016 = '0; instr_1511 = '0;
    md_retired = 0; stall_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
    check("reset_stall", stall_req, 1'b0);

    // Signed set-less-than
    rtype(6'h2A, 32'hFFFFFFFF, 32'd1);
    step(1'b1);
    check("slt_result", alu_result, 32'd1);
    check("slt_zero", zero_out, 1'b0);

    // MULT -3 * 7
    rtype(6'h18, 32'hFFFFFFFD, 32'd7);
    stall_seen = 0;
    run_md(-1, 0);
    check("mult_stall_cycles", stall_seen, 32);
    rtype(6'h10, $urandom, $urandom);
    step(1'b1);
    check("mfhi_mult", alu_result, 32'hFFFFFFFF);
    rtype(6'h12, $urandom, $urandom);
    step(1'b1);
    check("mflo_mult", alu_result, 32'hFFFFFFEB);

    // DIV -7 / 2
    rtype(6'h1A, 32'hFFFFFFF9, 32'd2);
    run_md(-1, 0);
    rtype(6'h12, $urandom, $urandom); step(1'b1);
    check("mflo_div", alu_result, 32'hFFFFFFFD);
    rtype(6'h10, $urandom, $urandom); step(1'b1);
    check("mfhi_div", alu_result, 32'hFFFFFFFF);

    // DIVU 5 / 0
    rtype(6'h1B, 32'd5, 32'd0);
    stall_seen = 0;
    run_md(-1, 0);
    check("divu0_stall_cycles", stall_seen, 32);
    rtype(6'h12, $urandom, $urandom); step(1'b1);
    check("mflo_divu0", alu_result, 32'hFFFFFFFF);
    rtype(6'h10, $urandom, $urandom); step(1'b1);
    check("mfhi_divu0", alu_result, 32'd5);

    // MULT with a 5-cycle freeze partway through
    rtype(6'h19, 32'd123456, 32'd789);
    stall_seen = 0;
    run_md(10, 5);
    check("freeze_stall_cycles", stall_seen, 37);
    rtype(6'h12, $urandom, $urandom); step(1'b1);
    check("mflo_multu", alu_result, 32'd97406784);

    // Reset while a DIVU sits at count 10
    rtype(6'h1B, 32'd1000, 32'd7);
    repeat (11) step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    rtype(6'h10, $urandom, $urandom); step(1'b1);
    check("mfhi_after_rst", alu_result, 32'd0);
    rtype(6'h12, $urandom, $urandom); step(1'b1);
    check("mflo_after_rst", alu_result, 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        f = md_list[$urandom_range(0, 3)];
        set_instr({2'($urandom_range(0, 3)) == 0 ? 1'b1 : 1'b0, 2'b10, 1'($urandom_range(0, 5) == 0)},
                  {24'($urandom), f}, rand_op(), rand_op());
      end else begin
        ctl = 4'($urandom);
        f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 6)];
        set_instr(ctl, {24'($urandom), f}, rand_op(), rand_op());
      end
      md_retired = 0;
      step($urandom_range(0, 7) != 0);
      for (int k = 0; k < 400 && is_md_now() && !md_retired; k++)
        step($urandom_range(0, 7) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
